bus_arbiter: RTL and testbench

Registered three-master arbiter for the z80computer system bus, replacing the one-cycle priority mux in front of external memory. It grants the shared address/data/control bus to the CPU, UART master or VGA master, holds each grant until the slave acknowledges, and applies fixed priority with a starvation guard. The granted master's signals are driven onto the bus from registered ownership state.

---
 rtl/bus_arbiter_if.sv | 30 +++
 rtl/bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Request bundle from the three bus masters plus the shared slave-side bus of bus_arbiter.
// slave: arbiter view; master: view of the masters and slave that surround it.
interface bus_arbiter_if;
   localparam int unsigned N_M = 3;
   localparam int unsigned AW  = 16;
   localparam int unsigned DW  = 8;

   logic [N_M-1:0]    i_m_cs;
   logic [N_M-1:0]    i_m_we;
   logic [N_M*AW-1:0] i_m_addr;
   logic [N_M*DW-1:0] i_m_dat;
   logic [N_M-1:0]    o_m_gnt;
   logic [N_M-1:0]    o_m_ack;
   logic [N_M-1:0]    o_m_err;
   logic [AW-1:0]     o_addr;
   logic [DW-1:0]     o_dat;
   logic              o_we;
   logic              o_cs;
   logic              i_ack;

   modport slave (
      input  i_m_cs, i_m_we, i_m_addr, i_m_dat, i_ack,
      output o_m_gnt, o_m_ack, o_m_err, o_addr, o_dat, o_we, o_cs
   );

   modport master (
      output i_m_cs, i_m_we, i_m_addr, i_m_dat, i_ack,
      input  o_m_gnt, o_m_ack, o_m_err, o_addr, o_dat, o_we, o_cs
   );
endinterface

// File: rtl/bus_arbiter.sv
// Registered three-master (CPU/UART/VGA) system-bus arbiter with fixed priority and starvation guard.
// Optional grant timeout is enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter #(
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned TIMEOUT      = 255
) (
   input  logic         i_clk,
   input  logic         i_reset_n,
   bus_arbiter_if.slave bus
);
   localparam int unsigned N_M = 3;
   localparam int unsigned AW  = 16;
   localparam int unsigned DW  = 8;
   localparam int unsigned CW  = 4;
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [1:0]             owner_q, owner_d;
   logic [N_M-1:0]         gnt_q, gnt_d;
   logic [N_M-1:0][CW-1:0] starve_q, starve_d;

   logic [N_M-1:0] starving, pool, own_onehot;
   logic [1:0]     winner;
   logic           own_cs, own_we;
   logic [AW-1:0]  own_addr;
   logic [DW-1:0]  own_dat;

`ifdef BUS_ARBITER_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
   logic [7:0] to_cnt_q;

   // Counts GRANT cycles without an acknowledge; cleared whenever not in GRANT.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)             to_cnt_q <= '0;
      else if (state_q != GRANT)  to_cnt_q <= '0;
      else if (!bus.i_ack)        to_cnt_q <= to_cnt_q + 8'(1);
   end
`else
   logic unused_timeout;
   assign unused_timeout = |8'(TIMEOUT);
`endif

   // Starved requesters take precedence; within a pool the highest index wins.
   always_comb begin
      starving = '0;
      for (int k = 0; k < N_M; k++)
         starving[k] = bus.i_m_cs[k] && (starve_q[k] == LIMIT);
      pool   = (|starving) ? starving : bus.i_m_cs;
      winner = 2'd0;
      if (pool[2])      winner = 2'd2;
      else if (pool[1]) winner = 2'd1;
   end

   always_comb begin
      own_cs   = 1'b0;
      own_we   = 1'b0;
      own_addr = '0;
      own_dat  = '0;
      case (owner_q)
         2'd0: begin
            own_cs   = bus.i_m_cs[0];
            own_we   = bus.i_m_we[0];
            own_addr = bus.i_m_addr[AW-1:0];
            own_dat  = bus.i_m_dat[DW-1:0];
         end
         2'd1: begin
            own_cs   = bus.i_m_cs[1];
            own_we   = bus.i_m_we[1];
            own_addr = bus.i_m_addr[2*AW-1:AW];
            own_dat  = bus.i_m_dat[2*DW-1:DW];
         end
         2'd2: begin
            own_cs   = bus.i_m_cs[2];
            own_we   = bus.i_m_we[2];
            own_addr = bus.i_m_addr[3*AW-1:2*AW];
            own_dat  = bus.i_m_dat[3*DW-1:2*DW];
         end
         default: ;
      endcase
      own_onehot = N_M'(1) << owner_q;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q  <= IDLE;
         owner_q  <= 2'd0;
         gnt_q    <= '0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         gnt_q    <= gnt_d;
         starve_q <= starve_d;
      end
   end

   // Bus outputs are only live in GRANT; ack/err are same-cycle strobes to the owner.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      gnt_d       = gnt_q;
      starve_d    = starve_q;
      bus.o_m_ack = '0;
      bus.o_m_err = '0;
      bus.o_addr  = '0;
      bus.o_dat   = '0;
      bus.o_we    = 1'b0;
      bus.o_cs    = 1'b0;

      for (int k = 0; k < N_M; k++)
         if (!bus.i_m_cs[k]) starve_d[k] = '0;

      case (state_q)
         IDLE: begin
            if (|bus.i_m_cs) begin
               state_d = GRANT;
               owner_d = winner;
               gnt_d   = N_M'(1) << winner;
               for (int k = 0; k < N_M; k++) begin
                  if (2'(k) == winner)
                     starve_d[k] = '0;
                  else if (bus.i_m_cs[k] && (starve_q[k] < LIMIT))
                     starve_d[k] = starve_q[k] + CW'(1);
               end
            end
         end
         GRANT: begin
            bus.o_cs   = own_cs;
            bus.o_we   = own_we && own_cs && (owner_q != 2'd2);
            bus.o_addr = own_addr;
            bus.o_dat  = own_dat;
            if (bus.i_ack && own_cs) begin
               bus.o_m_ack = own_onehot;
               state_d     = RELEASE;
               gnt_d       = '0;
            end else if (!own_cs) begin
               state_d = RELEASE;
               gnt_d   = '0;
            end
`ifdef BUS_ARBITER_TIMEOUT_EN
            else if (to_cnt_q == TO_LAST) begin
               bus.o_m_ack = own_onehot;
               bus.o_m_err = own_onehot;
               state_d     = RELEASE;
               gnt_d       = '0;
            end
`endif
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.o_m_gnt = gnt_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (STARVE_LIMIT=2, TIMEOUT=4).
module tb_bus_arbiter;
   localparam int unsigned STARVE_LIMIT = 2;
   localparam int unsigned TIMEOUT      = 4;

   logic        i_clk = 1'b0;
   logic        i_reset_n;
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   bus_arbiter_if bus ();

   bus_arbiter #(
      .STARVE_LIMIT(STARVE_LIMIT),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .i_clk    (i_clk),
      .i_reset_n(i_reset_n),
      .bus      (bus)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic bus_chk(input string tag, input logic [2:0] gnt, input logic cs, input logic we,
                          input logic [15:0] addr, input logic [7:0] dat);
      check({tag, ".gnt"},  32'(bus.o_m_gnt), 32'(gnt));
      check({tag, ".cs"},   32'(bus.o_cs),    32'(cs));
      check({tag, ".we"},   32'(bus.o_we),    32'(we));
      check({tag, ".addr"}, 32'(bus.o_addr),  32'(addr));
      check({tag, ".dat"},  32'(bus.o_dat),   32'(dat));
   endtask

   // Called at the negedge of a GRANT cycle; returns inside the following RELEASE cycle.
   task automatic serve(input string tag, input logic [2:0] gnt, input logic we,
                        input logic [15:0] addr, input logic [7:0] dat);
      #1;
      bus_chk({tag, ".grant"}, gnt, 1'b1, we, addr, dat);
      check({tag, ".preack"}, 32'(bus.o_m_ack), 32'(0));
      bus.i_ack = 1'b1;
      #1;
      check({tag, ".ack"}, 32'(bus.o_m_ack), 32'(gnt));
      check({tag, ".err"}, 32'(bus.o_m_err), 32'(0));
      @(negedge i_clk);
      bus.i_ack = 1'b0;
      #1;
      bus_chk({tag, ".release"}, 3'b000, 1'b0, 1'b0, 16'h0000, 8'h00);
   endtask

   initial begin
      i_reset_n    = 1'b0;
      bus.i_m_cs   = '0;
      bus.i_m_we   = '0;
      bus.i_m_addr = '0;
      bus.i_m_dat  = '0;
      bus.i_ack    = 1'b0;
      #2;
      bus_chk("reset", 3'b000, 1'b0, 1'b0, 16'h0000, 8'h00);
      check("reset.ack", 32'(bus.o_m_ack), 32'(0));
      check("reset.err", 32'(bus.o_m_err), 32'(0));
      @(negedge i_clk);
      i_reset_n = 1'b1;
      @(negedge i_clk);

      // CPU alone, slave acks two cycles after cs
      bus.i_m_cs   = 3'b001;
      bus.i_m_we   = 3'b001;
      bus.i_m_addr = {16'h0000, 16'h0000, 16'h1234};
      bus.i_m_dat  = {8'h00, 8'h00, 8'hA5};
      #1;
      check("cpu.idle_gnt", 32'(bus.o_m_gnt), 32'(0));
      check("cpu.idle_cs",  32'(bus.o_cs),    32'(0));
      @(negedge i_clk);
      #1;
      bus_chk("cpu.grant", 3'b001, 1'b1, 1'b1, 16'h1234, 8'hA5);
      check("cpu.noack", 32'(bus.o_m_ack), 32'(0));
      @(negedge i_clk);
      bus.i_ack = 1'b1;
      #1;
      check("cpu.ack", 32'(bus.o_m_ack), 32'(3'b001));
      check("cpu.ack_gnt", 32'(bus.o_m_gnt), 32'(3'b001));
      @(negedge i_clk);
      bus.i_ack = 1'b0;
      #1;
      bus_chk("cpu.release", 3'b000, 1'b0, 1'b0, 16'h0000, 8'h00);
      bus.i_m_cs = 3'b000;
      @(negedge i_clk);

      // Contention: VGA, then UART, then CPU
      bus.i_m_cs   = 3'b111;
      bus.i_m_we   = 3'b111;
      bus.i_m_addr = {16'hC000, 16'hB000, 16'hA000};
      bus.i_m_dat  = {8'h3C, 8'h5A, 8'hA5};
      @(negedge i_clk);
      serve("cont.vga", 3'b100, 1'b0, 16'hC000, 8'h3C);
      bus.i_m_cs = 3'b011;
      @(negedge i_clk);
      #1;
      check("cont.idle1", 32'(bus.o_m_gnt), 32'(0));
      @(negedge i_clk);
      serve("cont.uart", 3'b010, 1'b1, 16'hB000, 8'h5A);
      bus.i_m_cs = 3'b001;
      @(negedge i_clk);
      #1;
      check("cont.idle2", 32'(bus.o_m_gnt), 32'(0));
      @(negedge i_clk);
      serve("cont.cpu", 3'b001, 1'b1, 16'hA000, 8'hA5);
      bus.i_m_cs = 3'b000;
      @(negedge i_clk);

      // Starvation: CPU loses twice (to VGA), then is forced to win
      bus.i_m_cs = 3'b101;
      bus.i_m_we = 3'b000;
      @(negedge i_clk);
      serve("starve.a1", 3'b100, 1'b0, 16'hC000, 8'h3C);
      bus.i_m_cs = 3'b111;
      @(negedge i_clk);
      @(negedge i_clk);
      serve("starve.a2", 3'b100, 1'b0, 16'hC000, 8'h3C);
      @(negedge i_clk);
      @(negedge i_clk);
      serve("starve.a3", 3'b001, 1'b0, 16'hA000, 8'hA5);
      check("starve.cpu_cnt",  32'(dut.starve_q[0]), 32'(0));
      check("starve.uart_cnt", 32'(dut.starve_q[1]), 32'(2));
      bus.i_m_cs = 3'b000;
      @(negedge i_clk);

      // Abort: UART drops cs before ack, pending CPU follows
      bus.i_m_cs = 3'b011;
      bus.i_m_we = 3'b011;
      @(negedge i_clk);
      #1;
      check("abort.gnt", 32'(bus.o_m_gnt), 32'(3'b010));
      bus.i_m_cs = 3'b001;
      #1;
      check("abort.noack", 32'(bus.o_m_ack), 32'(0));
      check("abort.cs",    32'(bus.o_cs),    32'(0));
      @(negedge i_clk);
      #1;
      check("abort.release", 32'(bus.o_m_gnt), 32'(0));
      check("abort.rel_ack", 32'(bus.o_m_ack), 32'(0));
      @(negedge i_clk);
      #1;
      check("abort.idle", 32'(bus.o_m_gnt), 32'(0));
      @(negedge i_clk);
      serve("abort.cpu", 3'b001, 1'b1, 16'hA000, 8'hA5);
      bus.i_m_cs = 3'b000;
      @(negedge i_clk);

      // Timeout: CPU granted, slave never acks
      bus.i_m_cs = 3'b001;
      bus.i_m_we = 3'b000;
      @(negedge i_clk);
      #1;
      check("to.gnt", 32'(bus.o_m_gnt), 32'(3'b001));
      check("to.err1", 32'(bus.o_m_err), 32'(0));
`ifdef BUS_ARBITER_TIMEOUT_EN
      for (int c = 2; c < 4; c++) begin
         @(negedge i_clk);
         #1;
         check("to.early_err", 32'(bus.o_m_err), 32'(0));
         check("to.early_ack", 32'(bus.o_m_ack), 32'(0));
      end
      @(negedge i_clk);
      #1;
      check("to.err", 32'(bus.o_m_err), 32'(3'b001));
      check("to.ack", 32'(bus.o_m_ack), 32'(3'b001));
      @(negedge i_clk);
      #1;
      check("to.release", 32'(bus.o_m_gnt), 32'(0));
      check("to.rel_err", 32'(bus.o_m_err), 32'(0));
`else
      repeat (1000) @(negedge i_clk);
      #1;
      check("to.hold_gnt", 32'(bus.o_m_gnt), 32'(3'b001));
      check("to.hold_err", 32'(bus.o_m_err), 32'(0));
      bus.i_ack = 1'b1;
      #1;
      check("to.late_ack", 32'(bus.o_m_ack), 32'(3'b001));
      @(negedge i_clk);
      bus.i_ack = 1'b0;
`endif
      bus.i_m_cs = 3'b000;
      @(negedge i_clk);
      @(negedge i_clk);

      // Reset in the middle of a UART grant
      bus.i_m_cs = 3'b011;
      bus.i_m_we = 3'b011;
      @(negedge i_clk);
      #1;
      check("rst.pre_gnt", 32'(bus.o_m_gnt), 32'(3'b010));
      check("rst.pre_cpu_cnt", 32'(dut.starve_q[0]), 32'(1));
      #1;
      i_reset_n = 1'b0;
      bus.i_ack = 1'b1;
      #1;
      bus_chk("rst.mid", 3'b000, 1'b0, 1'b0, 16'h0000, 8'h00);
      check("rst.mid_ack", 32'(bus.o_m_ack), 32'(0));
      check("rst.cpu_cnt", 32'(dut.starve_q[0]), 32'(0));
      @(negedge i_clk);
      bus.i_ack = 1'b0;
      i_reset_n = 1'b1;
      #1;
      check("rst.idle", 32'(bus.o_m_gnt), 32'(0));
      @(negedge i_clk);
      serve("rst.uart", 3'b010, 1'b1, 16'hB000, 8'h5A);
      check("rst.cpu_cnt2", 32'(dut.starve_q[0]), 32'(1));
      bus.i_m_cs = 3'b000;
      @(negedge i_clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
